pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Each cycle it decides which of the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold or load a bubble, and whether the PC updates. It also runs the halt drain sequence until the halt instruction retires. It sits beside the pipeline registers in the datapath and owns their enable and flush inputs.

---
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: register enables, bubbles, PC update, halt drain.
// Optional feature macro: PIPELINE_CTRL_FORWARDING_EN (forwarding present, only load-use stalls).
module pipeline_ctrl (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dreq,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_halt,
    input  logic       ex_RegWr,
    input  logic       ex_MemtoReg,
    input  logic [4:0] ex_WrDest,
    input  logic       mem_RegWr,
    input  logic [4:0] mem_WrDest,
    input  logic       mem_take,
    input  logic       wb_Halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halt,
    output logic [1:0] dbg_state
);

    // Handshake note: there is no valid/ready pair here; ihit and dhit are
    // single-cycle completion strobes sampled combinationally each cycle.

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic dstall;
    logic ex_match;
    logic data_hz;
    logic fetch_stop;
    logic halt_q;

    assign dstall   = mem_dreq & ~dhit;
    assign ex_match = (ex_WrDest != 5'd0) &&
                      ((ex_WrDest == id_rs) || (id_uses_rt && (ex_WrDest == id_rt)));

`ifdef PIPELINE_CTRL_FORWARDING_EN
    // Results are forwarded, so only a load feeding the next instruction stalls.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{mem_RegWr, mem_WrDest};
    assign data_hz = ex_RegWr & ex_MemtoReg & ex_match;
`else
    // No forwarding: wait until the producer sits in MEM/WB, where the
    // write-before-read register file makes its result visible to ID.
    logic mem_match;
    assign mem_match = (mem_WrDest != 5'd0) &&
                       ((mem_WrDest == id_rs) || (id_uses_rt && (mem_WrDest == id_rt)));
    assign data_hz = (ex_RegWr & ex_match) | (mem_RegWr & mem_match);
`endif

    // A halt entering ID/EX stops fetch in the same cycle it is accepted.
    assign fetch_stop = ~ihit | (state_q == DRAIN) | id_halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (!nRST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q != HALTED) begin
            // Flushed registers keep their enable high so the bubble is loaded.
            if (dstall) begin
                pc_en = 1'b0;
            end else if (mem_take) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (data_hz) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end else if (fetch_stop) begin
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end

            case (state_q)
                RUN: begin
                    if (id_halt && !dstall && !mem_take && !data_hz)
                        state_d = DRAIN;
                end
                DRAIN: begin
                    // The halt retiring wins even over a frozen data access.
                    if (wb_Halt)
                        state_d = HALTED;
                    else if (mem_take && !dstall)
                        state_d = RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign halt      = halt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, mem_dreq;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt, id_halt;
    logic       ex_RegWr, ex_MemtoReg;
    logic [4:0] ex_WrDest;
    logic       mem_RegWr;
    logic [4:0] mem_WrDest;
    logic       mem_take, wb_Halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic       halt;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model mode: 0 running, 1 draining, 2 halted.
    int m_mode = 0;

    logic [7:0] exp_q[$];

    wire [7:0] outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush};

    localparam logic [7:0] V_RESET  = 8'b00000_111;
    localparam logic [7:0] V_FREEZE = 8'b00000_000;
    localparam logic [7:0] V_TAKE   = 8'b11111_111;
    localparam logic [7:0] V_LUSE   = 8'b00111_010;
    localparam logic [7:0] V_NOFET  = 8'b01111_100;
    localparam logic [7:0] V_RUN    = 8'b11111_000;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg), .ex_WrDest(ex_WrDest),
        .mem_RegWr(mem_RegWr), .mem_WrDest(mem_WrDest), .mem_take(mem_take),
        .wb_Halt(wb_Halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt),
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // Reference model
    function automatic bit reads_reg(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic bit model_hazard();
`ifdef PIPELINE_CTRL_FORWARDING_EN
        return ex_RegWr && ex_MemtoReg && reads_reg(ex_WrDest);
`else
        return (ex_RegWr && reads_reg(ex_WrDest)) || (mem_RegWr && reads_reg(mem_WrDest));
`endif
    endfunction

    function automatic logic [7:0] model_out();
        if (!nRST) return V_RESET;
        if (m_mode == 2) return V_FREEZE;
        if (mem_dreq && !dhit) return V_FREEZE;
        if (mem_take) return V_TAKE;
        if (model_hazard()) return V_LUSE;
        if (!ihit || m_mode == 1 || id_halt) return V_NOFET;
        return V_RUN;
    endfunction

    function automatic int model_next();
        bit frozen = mem_dreq && !dhit;
        if (!nRST) return 0;
        if (m_mode == 0 && id_halt && !frozen && !mem_take && !model_hazard()) return 1;
        if (m_mode == 1 && wb_Halt) return 2;
        if (m_mode == 1 && mem_take && !frozen) return 0;
        return m_mode;
    endfunction

    // Driver tasks
    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_halt = 1'b0;
        ex_RegWr = 1'b0; ex_MemtoReg = 1'b0; ex_WrDest = 5'd0;
        mem_RegWr = 1'b0; mem_WrDest = 5'd0; mem_take = 1'b0; wb_Halt = 1'b0;
    endtask

    task automatic advance();
        int nxt;
        nxt = model_next();
        @(posedge CLK);
        m_mode = nxt;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        advance();
        nRST = 1'b1;
    endtask

    task automatic enter_drain();
        do_reset();
        id_halt = 1'b1;
        advance();
        id_halt = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #1;
        total++;
        if (outs !== V_RESET) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, V_RESET); end
        total++;
        if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
        advance();
        nRST = 1'b1;
        #1;
        total++;
        if (outs !== V_RUN) begin bad++; $display("FAIL post_reset_run got=%b exp=%b", outs, V_RUN); end
        advance();
    endtask

    task automatic test_load_use();
        logic [7:0] exp_second;
        do_reset();
        ex_RegWr = 1'b1; ex_MemtoReg = 1'b1; ex_WrDest = 5'd2; id_rs = 5'd2;
        #1;
        total++;
        if (outs !== V_LUSE) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", outs, V_LUSE); end
        advance();
        ex_RegWr = 1'b0; ex_MemtoReg = 1'b0; ex_WrDest = 5'd0;
        mem_RegWr = 1'b1; mem_WrDest = 5'd2; mem_dreq = 1'b1; dhit = 1'b1;
`ifdef PIPELINE_CTRL_FORWARDING_EN
        exp_second = V_RUN;
`else
        exp_second = V_LUSE;
`endif
        #1;
        total++;
        if (outs !== exp_second) begin bad++; $display("FAIL load_use_second got=%b exp=%b", outs, exp_second); end
        advance();
        // rt match only counts when rt is read
        idle_inputs();
        ex_RegWr = 1'b1; ex_MemtoReg = 1'b1; ex_WrDest = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
        #1;
        total++;
        if (outs !== V_RUN) begin bad++; $display("FAIL load_use_rt_unused got=%b exp=%b", outs, V_RUN); end
        id_uses_rt = 1'b1;
        #1;
        total++;
        if (outs !== V_LUSE) begin bad++; $display("FAIL load_use_rt_used got=%b exp=%b", outs, V_LUSE); end
        ex_WrDest = 5'd0; id_rt = 5'd0;
        #1;
        total++;
        if (outs !== V_RUN) begin bad++; $display("FAIL load_use_r0 got=%b exp=%b", outs, V_RUN); end
        advance();
    endtask

    task automatic test_dstall();
        do_reset();
        mem_dreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (outs !== V_FREEZE) begin bad++; $display("FAIL dstall_cycle%0d got=%b exp=%b", i, outs, V_FREEZE); end
            advance();
        end
        dhit = 1'b1;
        #1;
        total++;
        if (outs !== V_RUN) begin bad++; $display("FAIL dstall_release got=%b exp=%b", outs, V_RUN); end
        advance();
        mem_dreq = 1'b0; ihit = 1'b0;
        #1;
        total++;
        if (outs !== V_NOFET) begin bad++; $display("FAIL ifetch_miss got=%b exp=%b", outs, V_NOFET); end
        advance();
    endtask

    task automatic test_take_priority();
        do_reset();
        ex_RegWr = 1'b1; ex_MemtoReg = 1'b1; ex_WrDest = 5'd4; id_rs = 5'd4; mem_take = 1'b1;
        #1;
        total++;
        if (outs !== V_TAKE) begin bad++; $display("FAIL take_over_luse got=%b exp=%b", outs, V_TAKE); end
        advance();
        idle_inputs();
        id_halt = 1'b1; mem_take = 1'b1;
        #1;
        total++;
        if (outs !== V_TAKE) begin bad++; $display("FAIL take_with_halt got=%b exp=%b", outs, V_TAKE); end
        advance();
        idle_inputs();
        #1;
        total++;
        if (outs !== V_RUN) begin bad++; $display("FAIL take_stays_run got=%b exp=%b", outs, V_RUN); end
        advance();
    endtask

    task automatic test_halt_drain();
        do_reset();
        id_halt = 1'b1;
        #1;
        total++;
        if (outs !== V_NOFET) begin bad++; $display("FAIL halt_accept got=%b exp=%b", outs, V_NOFET); end
        advance();
        id_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (outs !== V_NOFET || halt !== 1'b0) begin
                bad++; $display("FAIL drain_cycle%0d got=%b/%b exp=%b/0", i, outs, halt, V_NOFET);
            end
            advance();
        end
        wb_Halt = 1'b1; mem_dreq = 1'b1; dhit = 1'b0;
        #1;
        total++;
        if (outs !== V_FREEZE || halt !== 1'b0) begin
            bad++; $display("FAIL drain_retire got=%b/%b exp=%b/0", outs, halt, V_FREEZE);
        end
        advance();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (outs !== V_FREEZE || halt !== 1'b1) begin
                bad++; $display("FAIL halted_cycle%0d got=%b/%b exp=%b/1", i, outs, halt, V_FREEZE);
            end
            advance();
        end
    endtask

    task automatic test_drain_branch();
        enter_drain();
        mem_take = 1'b1; mem_dreq = 1'b1; dhit = 1'b0;
        #1;
        total++;
        if (outs !== V_FREEZE) begin bad++; $display("FAIL drain_take_frozen got=%b exp=%b", outs, V_FREEZE); end
        advance();
        idle_inputs();
        #1;
        total++;
        if (outs !== V_NOFET) begin bad++; $display("FAIL drain_held got=%b exp=%b", outs, V_NOFET); end
        mem_take = 1'b1;
        #1;
        total++;
        if (outs !== V_TAKE) begin bad++; $display("FAIL drain_take got=%b exp=%b", outs, V_TAKE); end
        advance();
        idle_inputs();
        #1;
        total++;
        if (outs !== V_RUN || halt !== 1'b0) begin
            bad++; $display("FAIL drain_resume got=%b/%b exp=%b/0", outs, halt, V_RUN);
        end
        advance();
    endtask

    task automatic test_reset_mid_drain();
        enter_drain();
        nRST = 1'b0;
        #1;
        total++;
        if (outs !== V_RESET) begin bad++; $display("FAIL mid_drain_reset got=%b exp=%b", outs, V_RESET); end
        advance();
        nRST = 1'b1;
        #1;
        total++;
        if (outs !== V_RUN || halt !== 1'b0) begin
            bad++; $display("FAIL mid_drain_resume got=%b/%b exp=%b/0", outs, halt, V_RUN);
        end
        advance();
    endtask

    task automatic test_raw_stall();
        int stalls = 0;
        int stage = 1;
        int exp_stalls;
`ifdef PIPELINE_CTRL_FORWARDING_EN
        exp_stalls = 0;
`else
        exp_stalls = 2;
`endif
        do_reset();
        id_rs = 5'd3;
        for (int i = 0; i < 6; i++) begin
            ex_RegWr = (stage == 1); ex_WrDest = (stage == 1) ? 5'd3 : 5'd0;
            mem_RegWr = (stage == 2); mem_WrDest = (stage == 2) ? 5'd3 : 5'd0;
            #1;
            if (outs == V_LUSE) begin
                stalls++;
                stage++;
                advance();
            end else begin
                advance();
                break;
            end
        end
        total++;
        if (stalls !== exp_stalls) begin bad++; $display("FAIL raw_stall_count got=%0d exp=%0d", stalls, exp_stalls); end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        logic       exp_halt;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            nRST       = ($urandom_range(0, 63) != 0);
            ihit       = ($urandom_range(0, 3) != 0);
            mem_dreq   = $urandom_range(0, 1);
            dhit       = $urandom_range(0, 1);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = $urandom_range(0, 1);
            id_halt    = ($urandom_range(0, 7) == 0);
            ex_RegWr   = $urandom_range(0, 1);
            ex_MemtoReg = $urandom_range(0, 1);
            ex_WrDest  = 5'($urandom_range(0, 3));
            mem_RegWr  = $urandom_range(0, 1);
            mem_WrDest = 5'($urandom_range(0, 3));
            mem_take   = ($urandom_range(0, 7) == 0);
            wb_Halt    = ($urandom_range(0, 7) == 0);
            exp_q.push_back(model_out());
            exp_halt = nRST && (m_mode == 2);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (outs !== exp) begin bad++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", i, outs, exp); end
            total++;
            if (halt !== exp_halt) begin bad++; $display("FAIL rand_halt cyc=%0d got=%b exp=%b", i, halt, exp_halt); end
            advance();
        end
    endtask

    // Sequence and final report
    initial begin
        idle_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_dstall();
        test_take_priority();
        test_halt_drain();
        test_drain_branch();
        test_reset_mid_drain();
        test_raw_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
